// File: rtl/mult_arbiter.sv
// Two-requester front end for one shared combinational 16x16 multiplier.
// Round-robin grant, registered operands, product sampled after SETTLE_CYCLES.
module mult_arbiter #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_p,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_p,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p,
  output logic        busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the same requester's data, only on valid.
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] mul_a_q, mul_a_d;
  logic [15:0] mul_b_q, mul_b_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;

  logic grant;
  logic accept;
  logic rsp_ready_g;

  // On a tie the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = req1_valid;
  end

  assign req0_ready  = rst_n && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready  = rst_n && (state_q == IDLE) && req1_valid &&  grant;
  assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_ready_g = gnt_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d  = state_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mul_a_d = grant ? req1_a : req0_a;
          mul_b_d = grant ? req1_b : req0_b;
          gnt_d   = grant;
          last_d  = grant;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          result_d = mul_p;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_g) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign busy       = (state_q != IDLE);
  assign rsp0_valid = (state_q == RESP) && !gnt_q;
  assign rsp1_valid = (state_q == RESP) &&  gnt_q;
  assign rsp0_p     = rsp0_valid ? result_q : 32'd0;
  assign rsp1_p     = rsp1_valid ? result_q : 32'd0;

endmodule
